// File: rtl/mul_pkg.sv
// Shared types and default sizing for the shift-and-add multiplier.
package mul_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/adder_8bits.sv
// Ripple-carry adder, purely combinational; cout is the carry out of the MSB.
module adder_8bits #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier, one partial product per clock, valid/ready on both sides.
// SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o
);
  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mreg;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH:0]     step;
  logic [2*WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] final_prod;
  logic               last;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
  logic [WIDTH-1:0]   rem_mask;
`endif

  adder_8bits #(.WIDTH(WIDTH)) u_add (
    .a    (acc),
    .b    (mreg),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  // carry is always zero after the shift, so it doubles as a clean carry-in
  always_comb begin
    step    = mq[0] ? {cout, sum} : {1'b0, acc};
    shifted = {step, mq[WIDTH-1:1]};
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
    rem_mask   = {WIDTH{1'b1}} >> (int'(cnt) + 1);
    last       = ((mq >> 1) & rem_mask) == '0;
    final_prod = shifted >> (WIDTH - 1 - int'(cnt));
`else
    last       = (cnt == CNT_W'(WIDTH - 1));
    final_prod = shifted;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      acc       <= '0;
      mq        <= '0;
      mreg      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      product_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            mreg  <= mcand_i;
            mq    <= mplier_i;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          cnt   <= cnt + CNT_W'(1);
          carry <= 1'b0;
          if (last) begin
            {acc, mq} <= final_prod;
            product_o <= final_prod;
            state     <= DONE;
          end else begin
            {acc, mq} <= shifted;
          end
        end
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state == CALC) || (state == DONE);
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier; shift-and-add, one partial product per clock.
- Sits directly downstream of the team's ripple adder and consumes its sum/carry every iteration.
- Front end: valid/ready operand handshake. Back end: valid/ready product handshake.
- Used by the ALU multiply path where a single-cycle array multiplier is too large.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-low reset; sampled on clk_i rising edge.
- in_valid_i  in  1  operands present.
- in_ready_o  out  1  block can accept operands.
- mcand_i  in  WIDTH  multiplicand.
- mplier_i  in  WIDTH  multiplier.
- out_valid_o  out  1  product valid.
- out_ready_i  in  1  consumer accepts product.
- product_o  out  2*WIDTH  unsigned product.
- busy_o  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - State goes to IDLE.
  - Outputs: in_ready_o=1, out_valid_o=0, busy_o=0, product_o=0.
  - Internal registers clear: A=0, Q=0, M=0, C=0, cnt=0.
- Registers: A (WIDTH) accumulator, Q (WIDTH) multiplier/low product, M (WIDTH) multiplicand, C (1) carry, cnt (CNT_W).
- State IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o: M<=mcand_i, Q<=mplier_i, A<=0, C<=0, cnt<=0; go to CALC.
- State CALC:
  - in_ready_o=0; in_valid_i is ignored.
  - Each cycle: {C,A} = Q[0] ? A+M (WIDTH-bit add with carry-out) : {0,A}.
  - Then {C,A,Q} is shifted right by 1 (C enters A MSB, A LSB enters Q MSB).
  - cnt increments each cycle. When cnt==WIDTH-1, go to DONE.
- State DONE:
  - out_valid_o=1, product_o={A,Q}.
  - Product is held stable until out_ready_i=1; then go to IDLE.
- Latency: accept at edge N; out_valid_o rises after edge N+WIDTH (8 CALC cycles at WIDTH=8).
- Throughput: one product per WIDTH+2 cycles, with out_ready_i held high.
- No overlap: in_ready_o=0 in DONE, even when out_ready_i=1 in the same cycle. in_ready_o returns one cycle after the product handshake.
- out_valid_o and in_ready_o are decoded from the state register only, with no combinational path from inputs.
- product_o:
  - Registered.
  - Holds the last product in IDLE; is not cleared after the handshake.
  - Is 0 only after reset.
- Boundaries:
  - Either operand 0 -> product 0.
  - 255*255 -> 0xFE01; the carry-out is required to reach this value.
  - Carry is never lost: A+M can be at most 2^(WIDTH+1)-2, which fits {C,A}.
- Reset mid-CALC or mid-DONE:
  - Aborts the operation with no output.
  - Next cycle is IDLE with reset values.

Optional Feature:
- Macro: SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN.
- Defined:
  - In CALC, if the remaining unconsumed multiplier bits are all zero, the block skips the remaining cycles.
  - It applies the pending shift amount in one step ({A,Q} shifted right by remaining count, C=0) and enters DONE next cycle.
  - Product is identical to the non-early-exit result.
  - Latency ranges from 1 to WIDTH CALC cycles.
- Undefined:
  - Fixed WIDTH CALC cycles, per the Behaviour section.
  - No extra logic is present.

Decomposition:
- Package mul_pkg contains:
  - State enum: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - Default WIDTH and CNT_W constants.
- Sub-module: adder_8bits (the team's ripple adder) as the A+M stage at WIDTH=8; its cout drives C.
- Control FSM and shift registers stay in shift_add_multiplier.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles -> in_ready_o=1, out_valid_o=0, busy_o=0, product_o=0x0000.
- Basic product: 13*11 accepted at edge N -> out_valid_o high after edge N+8, product_o=0x008F.
- Maximum operands and backpressure: 255*255 with out_ready_i=0 for 5 cycles -> product_o=0xFE01 held stable with out_valid_o=1; accepted on the first cycle out_ready_i=1; in_ready_o=1 the next cycle.
- Zero and busy input: 0*200 -> 0x0000. Also drive in_valid_i=1 with new operands during CALC -> they are ignored; result still 0x0000.
- Back-to-back: 3 streamed ops (1*1, 128*2, 170*85) with out_ready_i=1 -> 0x0001, 0x0100, 0x3872, each spaced WIDTH+2 cycles apart.
- Reset mid-CALC: assert rst_i=0 at CALC cycle 4 of 200*3 -> no out_valid_o; IDLE next cycle. With EARLY_EXIT_EN defined, 5*1 -> DONE after 1 CALC cycle, product 0x0005.
